// File: rtl/system_onchip_mem_arb_pkg.sv
// Shared types and default sizes for the two-master on-chip memory arbiter.
// Holds the grant FSM state encoding and the default width constants.
package system_onchip_mem_arb_pkg;

    localparam int ARB_ADDR_W   = 13;
    localparam int ARB_DATA_W   = 64;
    localparam int ARB_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/system_onchip_mem_arb_grant.sv
// Grant FSM for two masters: ownership state, saturating hold counter, rr.
// Ports: clk, reset (sync, active-high), req0/req1 in, gnt0/gnt1 out.
module system_onchip_mem_arb_grant
    import system_onchip_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic             g0, g1;
    logic             keep;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    g0 = ~rr_q;
                    g1 = rr_q;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
            ST_OWN0: begin
                if (req0 && (!req1 || cnt_q < HOLD_MAX))
                    g0 = 1'b1;
                else
                    g1 = req1;
            end
            ST_OWN1: begin
                if (req1 && (!req0 || cnt_q < HOLD_MAX))
                    g1 = 1'b1;
                else
                    g0 = req0;
            end
            default: begin
                g0 = 1'b0;
                g1 = 1'b0;
            end
        endcase
    end

    // The current owner continuing is the only case that grows the count.
    assign keep = (g0 && state_q == ST_OWN0) ||
                  (g1 && state_q == ST_OWN1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (g0 || g1) begin
            state_d = g1 ? ST_OWN1 : ST_OWN0;
            rr_d    = g0;
            if (!keep)
                cnt_d = CNT_ONE;
            else if (cnt_q != HOLD_MAX)
                cnt_d = cnt_q + CNT_ONE;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt0 = g0 & ~reset;
    assign gnt1 = g1 & ~reset;

endmodule

// File: rtl/system_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous on-chip memory.
// Ports: clk, reset, m0_*/m1_* master buses, mem_* memory-side bus.
module system_onchip_mem_arbiter
    import system_onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    parameter int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req0, req1;
    logic gnt0, gnt1;
    logic tag_vld_q, tag_vld_d;
    logic tag_id_q, tag_id_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    system_onchip_mem_arb_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        unique case (1'b1)
            gnt0: begin
                mem_address    = m0_address;
                mem_byteenable = m0_byteenable;
                mem_writedata  = m0_writedata;
                mem_chipselect = 1'b1;
                mem_write      = m0_write;
            end
            gnt1: begin
                mem_address    = m1_address;
                mem_byteenable = m1_byteenable;
                mem_writedata  = m1_writedata;
                mem_chipselect = 1'b1;
                mem_write      = m1_write;
            end
            default: begin
                mem_chipselect = 1'b0;
            end
        endcase
    end

    assign mem_clken = ~reset;

    // Write wins over read, so a request with write set never tags a read.
    always_comb begin
        tag_vld_d = (gnt0 & ~m0_write) | (gnt1 & ~m1_write);
        tag_id_d  = gnt1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= 1'b0;
            tag_id_q  <= 1'b0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

    // Gating with reset drops a read that was granted just before reset.
    assign m0_readdatavalid = tag_vld_q & ~tag_id_q & ~reset;
    assign m1_readdatavalid = tag_vld_q & tag_id_q & ~reset;

endmodule

// File: doc/system_onchip_mem_arbiter.md
SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: system_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; BE_W = DATA_W/8.
REQ-003 SHALL have parameter MAX_HOLD, default 4, max consecutive beats one master keeps the grant while the other waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have, per master N in {0,1}: mN_address in ADDR_W; mN_byteenable in BE_W; mN_read in 1; mN_write in 1; mN_writedata in DATA_W.
REQ-007 SHALL have, per master N: mN_waitrequest out 1 (request not accepted this cycle); mN_readdata out DATA_W; mN_readdatavalid out 1.
REQ-008 SHALL have memory-side ports mem_address out ADDR_W, mem_byteenable out BE_W, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_clken out 1, mem_readdata in DATA_W.

Function
REQ-009 SHALL treat master N as requesting when mN_read | mN_write; if both asserted, SHALL issue a write and ignore the read.
REQ-010 SHALL grant at most one master per cycle; grant combinational from state and requests; transfer accepted in the cycle grant is given.
REQ-011 SHALL drive mN_waitrequest = request_N & ~grant_N; no waitrequest when not requesting.
REQ-012 SHALL drive memory from the granted master: mem_chipselect=1, mem_write=write, address/byteenable/writedata muxed; no grant -> mem_chipselect=0, mem_write=0, mem_byteenable=0.
REQ-013 SHALL drive mem_clken=1 except during reset.
REQ-014 SHALL implement FSM IDLE, OWN0, OWN1 with saturating hold counter (0..MAX_HOLD) and round-robin pointer rr.
REQ-015 IDLE: single requester granted; both requesting -> master rr granted; next state OWNx of grantee, counter=1; no request -> stay IDLE.
REQ-016 OWNx: if x requests and (other idle or counter<MAX_HOLD) -> grant x, counter+1 (saturate).
REQ-017 OWNx: else if other requests -> grant other, go OWN(other), counter=1.
REQ-018 OWNx: no request -> IDLE, counter=0.
REQ-019 rr SHALL update on every grant to point to the master not granted.
REQ-020 Read latency: granted read in cycle T -> mN_readdatavalid=1 for exactly cycle T+1 with mN_readdata=mem_readdata; other master's readdatavalid=0.
REQ-021 SHALL track the read with a 1-entry registered tag (valid, master id); back-to-back reads from alternating masters SHALL each return in order at T+1.
REQ-022 mN_readdata SHALL be mem_readdata irrespective of valid; only readdatavalid is qualified.
REQ-023 Writes SHALL produce no response; a write and a read to the same address on consecutive cycles SHALL return the new data.

Reset
REQ-024 On reset: state IDLE, counter 0, rr 0, read tag invalid.
REQ-025 While reset high: all waitrequest=1 for requesting masters, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-026 A read granted in the cycle before reset asserts SHALL NOT produce readdatavalid.

Structure
REQ-027 Shared package system_onchip_mem_arb_pkg SHALL hold FSM state enum and default width constants.
REQ-028 Grant FSM + hold counter + rr SHALL be sub-module system_onchip_mem_arb_grant; datapath muxing and read tag in top.

Verification
REQ-029 Only m0 reads 0x0010 each cycle x6 -> no waitrequest, readdatavalid each following cycle, data matches preload.
REQ-030 Both request from IDLE after reset -> m0 granted first (rr=0); MAX_HOLD=4: m0 gets 4 beats, then m1 granted, m0_waitrequest=1 that cycle.
REQ-031 m0 writes 0xDEADBEEF_01234567 to 0x0100, byteenable 0xFF; next cycle m1 reads 0x0100 -> m1_readdatavalid next cycle, data 0xDEADBEEF_01234567.
REQ-032 Write byteenable 0x0F of 0xFFFFFFFF_FFFFFFFF over 0 at 0x0200, read back -> 0x00000000_FFFFFFFF.
REQ-033 m0 and m1 alternate reads 0x0001/0x0002 with single-beat requests -> readdatavalid alternates m0,m1, each T+1, correct data.
REQ-034 Reset asserted the cycle after an m1 read grant -> no m1_readdatavalid; after release state IDLE, next contended grant goes to m0.
